// File: rtl/psum_ofifo_pkg.sv
// ofifo_pkg: shared definitions for the psum output FIFO.
//   PSUM_BW_DEF / COL_DEF : default psum width and column count
//   psum_t                : signed psum at the default width
//   ptr_w()               : FIFO pointer width (index bits plus one wrap bit)
package ofifo_pkg;

  localparam int unsigned PSUM_BW_DEF = 16;
  localparam int unsigned COL_DEF     = 8;

  typedef logic signed [PSUM_BW_DEF-1:0] psum_t;

  function automatic int unsigned ptr_w(input int unsigned depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/psum_ofifo_fifo_lane.sv
// fifo_lane: one column FIFO of the psum output collector, 1R1W register array.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-low reset (pointers only)
//   push, din  : write strobe and data; caller guarantees a free slot
//   pop        : advance read pointer; caller guarantees non-empty
//   dout       : current head (combinational read)
//   empty,full : occupancy flags from the wrap-bit pointer compare
module fifo_lane
  import ofifo_pkg::*;
#(
  parameter int unsigned W          = PSUM_BW_DEF,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PW    = ptr_w(DEPTH_LOG2);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [W-1:0]  mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[DEPTH_LOG2-1:0]] <= din;
  end

  // Head is read combinationally, so a push into the slot freed by a
  // same-cycle pop cannot disturb the value being popped.
  assign dout  = mem[rptr[DEPTH_LOG2-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]) &&
                 (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]);

endmodule

// File: rtl/psum_ofifo.sv
// psum_ofifo: output collector below the PE array. Per-column FIFOs absorb the
// skewed column completion; one full row is released per read handshake.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-low reset
//   in, wr     : column psums (column c at [c*PSUM_BW +: PSUM_BW]) and strobes
//   rd         : request one row; ignored unless o_valid
//   out        : registered row output, same packing as in
//   out_valid  : one-cycle pulse when out holds a newly popped row
//   o_valid    : every column holds at least one entry
//   o_full     : some column is full;  o_ready = ~o_full
//   overflow   : sticky, a write to a full column was dropped
// Build option: define PSUM_OFIFO_RELU_EN to clamp negative lanes of out to 0.
module psum_ofifo
  import ofifo_pkg::*;
#(
  parameter int unsigned COL        = COL_DEF,
  parameter int unsigned PSUM_BW    = PSUM_BW_DEF,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COL*PSUM_BW-1:0] in,
  input  logic [COL-1:0]         wr,
  input  logic                   rd,
  output logic [COL*PSUM_BW-1:0] out,
  output logic                   out_valid,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   overflow
);

  logic [COL-1:0]         empty_v;
  logic [COL-1:0]         full_v;
  logic [COL-1:0]         push_v;
  logic [COL*PSUM_BW-1:0] heads;
  logic [COL*PSUM_BW-1:0] row_next;
  logic                   pop;
  logic                   drop;

  assign o_valid = ~|empty_v;
  assign o_full  = |full_v;
  assign o_ready = ~o_full;
  assign pop     = rd & o_valid;

  // A same-cycle pop frees a slot, so a full lane still accepts the write.
  assign push_v = wr & (~full_v | {COL{pop}});
  assign drop   = |(wr & full_v) & ~pop;

  for (genvar c = 0; c < COL; c++) begin : g_lane
    fifo_lane #(
      .W          (PSUM_BW),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .push  (push_v[c]),
      .pop   (pop),
      .din   (in[c*PSUM_BW +: PSUM_BW]),
      .dout  (heads[c*PSUM_BW +: PSUM_BW]),
      .empty (empty_v[c]),
      .full  (full_v[c])
    );
  end

  always_comb begin
    row_next = heads;
`ifdef PSUM_OFIFO_RELU_EN
    for (int unsigned c = 0; c < COL; c++) begin
      if (heads[c*PSUM_BW + PSUM_BW - 1]) row_next[c*PSUM_BW +: PSUM_BW] = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= pop;
      if (pop)  out      <= row_next;
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_ofifo.sv
module tb_psum_ofifo;
  import ofifo_pkg::*;

  localparam int COLN = 8;
  localparam int BW   = 16;
  localparam int DEP  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [COLN*BW-1:0] in;
  logic [COLN-1:0]   wr;
  logic              rd;
  logic [COLN*BW-1:0] out;
  logic              out_valid, o_valid, o_full, o_ready, overflow;

  int ncmp = 0;
  int nfail = 0;

  // Reference model: one queue per column, a sticky drop flag, expected rows.
  logic [BW-1:0]      mq [COLN][$];
  logic [COLN*BW-1:0] exp_q [$];
  logic [COLN*BW-1:0] last_out;
  logic               ovf_m;

  psum_ofifo #(.COL(COLN), .PSUM_BW(BW), .DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
    .out_valid(out_valid), .o_valid(o_valid), .o_full(o_full),
    .o_ready(o_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [COLN*BW-1:0] obs,
                     input logic [COLN*BW-1:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [BW-1:0] lane_exp(input logic [BW-1:0] v);
    psum_t s;
    s = psum_t'(v);
`ifdef PSUM_OFIFO_RELU_EN
    if (s < 0) return '0;
`endif
    return v;
  endfunction

  function automatic logic model_valid();
    for (int c = 0; c < COLN; c++) if (mq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic model_full();
    for (int c = 0; c < COLN; c++) if (mq[c].size() == DEP) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_flags(input string tag);
    chk({tag, ".o_valid"},  {127'd0, o_valid},  {127'd0, model_valid()});
    chk({tag, ".o_full"},   {127'd0, o_full},   {127'd0, model_full()});
    chk({tag, ".o_ready"},  {127'd0, o_ready},  {127'd0, ~model_full()});
    chk({tag, ".overflow"}, {127'd0, overflow}, {127'd0, ovf_m});
  endtask

  // One clock: drive, update the model from pre-edge state, then compare.
  task automatic cycle(input string tag, input logic [COLN-1:0] w,
                       input logic [COLN*BW-1:0] d, input logic r);
    logic pop_m;
    logic [COLN*BW-1:0] row;
    logic [COLN-1:0] was_full;
    wr = w; in = d; rd = r;
    pop_m = r && model_valid();
    for (int c = 0; c < COLN; c++) was_full[c] = (mq[c].size() == DEP);
    if (pop_m) begin
      for (int c = 0; c < COLN; c++) row[c*BW +: BW] = lane_exp(mq[c].pop_front());
      exp_q.push_back(row);
    end
    for (int c = 0; c < COLN; c++) begin
      if (w[c]) begin
        if (!was_full[c] || pop_m) mq[c].push_back(d[c*BW +: BW]);
        else ovf_m = 1'b1;
      end
    end
    @(posedge clk); #1;
    chk({tag, ".out_valid"}, {127'd0, out_valid}, {127'd0, pop_m});
    if (pop_m) last_out = exp_q.pop_front();
    chk({tag, ".out"}, out, last_out);
    check_flags(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0; wr = '0; rd = 1'b0; in = '0;
    @(posedge clk); #1;
    for (int c = 0; c < COLN; c++) mq[c].delete();
    exp_q.delete();
    ovf_m = 1'b0;
    last_out = '0;
    chk({tag, ".out"}, out, '0);
    chk({tag, ".out_valid"}, {127'd0, out_valid}, '0);
    check_flags(tag);
    reset = 1'b1;
  endtask

  function automatic logic [COLN*BW-1:0] seq_row(input int base);
    logic [COLN*BW-1:0] r;
    for (int c = 0; c < COLN; c++) r[c*BW +: BW] = BW'(base * 8 + c);
    return r;
  endfunction

  initial begin
    logic [COLN*BW-1:0] d;
    logic [COLN*BW-1:0] want;
    reset = 1'b1; wr = '0; rd = 1'b0; in = '0;
    ovf_m = 1'b0; last_out = '0;
    @(posedge clk); #1;

    // 1 reset
    do_reset("reset");

    // 2 skewed column writes with rd held
    for (int c = 0; c < COLN; c++) begin
      d = '0;
      d[c*BW +: BW] = BW'(100 + c);
      cycle("skew_wr", COLN'(1 << c), d, 1'b1);
    end
    chk("skew_ovalid", {127'd0, o_valid}, {127'd0, 1'b1});
    cycle("skew_rd", '0, '0, 1'b1);
    for (int c = 0; c < COLN; c++) want[c*BW +: BW] = BW'(100 + c);
    chk("skew_row", out, want);
    cycle("skew_after", '0, '0, 1'b1);
    chk("skew_pulse", {127'd0, out_valid}, '0);

    // 3 fill, overflow, drain
    for (int i = 0; i < DEP; i++) cycle("fill", '1, seq_row(i + 1), 1'b0);
    chk("fill_full", {127'd0, o_full, o_ready}, {126'd0, 2'b10});
    cycle("fill_extra", '1, seq_row(99), 1'b0);
    chk("fill_ovf", {127'd0, overflow}, {127'd0, 1'b1});
    for (int i = 0; i < DEP + 1; i++) cycle("drain", '0, '0, 1'b1);
    chk("drain_last", out, seq_row(DEP));

    // 4 full lanes, write and pop in the same cycle
    do_reset("reset2");
    for (int i = 0; i < DEP; i++) cycle("fill2", '1, seq_row(i + 20), 1'b0);
    cycle("fullpop", '1, seq_row(77), 1'b1);
    chk("fullpop_ovf", {127'd0, overflow, o_full}, {126'd0, 2'b01});
    for (int i = 0; i < DEP; i++) cycle("drain2", '0, '0, 1'b1);
    chk("fullpop_new16", out, seq_row(77));

    // 5 streaming wrap, empty reads, mid-stream reset
    do_reset("reset3");
    for (int i = 0; i < 40; i++) cycle("stream", '1, seq_row(i + 200), 1'b1);
    cycle("stream_tail", '0, '0, 1'b1);
    chk("stream_last", out, seq_row(239));
    for (int i = 0; i < 3; i++) cycle("rd_empty", '0, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      cycle("mid_fill", '1, d, 1'b0);
    end
    do_reset("reset_mid");
    cycle("post_reset_rd", '0, '0, 1'b1);

    // 6 ReLU lanes
    d = {$urandom, $urandom, $urandom, $urandom};
    d[0 +: BW]  = 16'hFFFB;
    d[BW +: BW] = 16'd7;
    cycle("relu_wr", '1, d, 1'b0);
    cycle("relu_rd", '0, '0, 1'b1);
`ifdef PSUM_OFIFO_RELU_EN
    chk("relu_lane0", {112'd0, out[0 +: BW]}, 128'd0);
`else
    chk("relu_lane0", {112'd0, out[0 +: BW]}, {112'd0, 16'hFFFB});
`endif
    chk("relu_lane1", {112'd0, out[BW +: BW]}, {112'd0, 16'd7});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
